// File: rtl/larpix_rx_decoder_pkg.sv
// Shared LArPix packet constants, field layout and helpers for the RX decoder.
package larpix_rx_decoder_pkg;

  localparam int unsigned CNT_W = 16;

  // Packet declare codes carried in bits [1:0]
  localparam logic [1:0] DATA      = 2'b01;
  localparam logic [1:0] CFG_WRITE = 2'b10;
  localparam logic [1:0] CFG_READ  = 2'b11;

  // Field positions inside the received word
  localparam int unsigned DECLARE_LSB     = 0;
  localparam int unsigned DECLARE_W       = 2;
  localparam int unsigned CHIP_ID_LSB     = 2;
  localparam int unsigned CHIP_ID_W       = 8;
  localparam int unsigned CHANNEL_ID_LSB  = 10;
  localparam int unsigned CHANNEL_ID_W    = 6;
  localparam int unsigned TIMESTAMP_LSB   = 16;
  localparam int unsigned TIMESTAMP_W     = 28;
  localparam int unsigned DATA_WORD_LSB   = 46;
  localparam int unsigned DATA_WORD_W     = 10;
  localparam int unsigned TRIGGER_LSB     = 56;
  localparam int unsigned TRIGGER_W       = 2;
  localparam int unsigned REGMAP_ADDR_LSB = 10;
  localparam int unsigned REGMAP_ADDR_W   = 8;
  localparam int unsigned REGMAP_DATA_LSB = 18;
  localparam int unsigned REGMAP_DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UNLOAD  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } rx_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // True for declare codes that represent a real packet
  function automatic logic is_pkt_declare(input logic [DECLARE_W-1:0] d);
    return (d == DATA) || (d == CFG_WRITE) || (d == CFG_READ);
  endfunction

endpackage

// File: rtl/larpix_rx_decoder_if.sv
// Packet stream from the decoder FIFO head, with its combinationally decoded fields.
interface larpix_rx_decoder_if #(
  parameter int unsigned WIDTH = 64
);
  import larpix_rx_decoder_pkg::*;

  logic                       pkt_valid;
  logic                       pkt_ready;
  logic [WIDTH-2:0]           pkt_word;
  logic                       pkt_parity_err;
  logic [DECLARE_W-1:0]       pkt_type;
  logic [CHIP_ID_W-1:0]       pkt_chip_id;
  logic [CHANNEL_ID_W-1:0]    pkt_channel_id;
  logic [TIMESTAMP_W-1:0]     pkt_timestamp;
  logic [DATA_WORD_W-1:0]     pkt_data_word;
  logic [TRIGGER_W-1:0]       pkt_trigger_type;
  logic [REGMAP_ADDR_W-1:0]   pkt_regmap_addr;
  logic [REGMAP_DATA_W-1:0]   pkt_regmap_data;

  modport master (
    output pkt_valid, pkt_word, pkt_parity_err, pkt_type, pkt_chip_id,
           pkt_channel_id, pkt_timestamp, pkt_data_word, pkt_trigger_type,
           pkt_regmap_addr, pkt_regmap_data,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_word, pkt_parity_err, pkt_type, pkt_chip_id,
           pkt_channel_id, pkt_timestamp, pkt_data_word, pkt_trigger_type,
           pkt_regmap_addr, pkt_regmap_data,
    output pkt_ready
  );

endinterface

// File: rtl/larpix_rx_decoder_fifo.sv
// First-word-fall-through packet FIFO; a push into a full FIFO is only taken with a same-cycle pop.
module rx_pkt_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_en;
  logic             push_en;

  // Extra pointer bit distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Head reads as zero when empty so downstream fields are quiet
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/larpix_rx_decoder.sv
// Unloads words from uart_rx_fpga, filters/counts them and queues valid packets.
module larpix_rx_decoder
  import larpix_rx_decoder_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-2:0]     rx_data,
  input  logic                 rx_empty,
  input  logic                 parity_error,
  output logic                 uld_rx_data,
  larpix_rx_decoder_if.master  pkt,
  output logic [CNT_W-1:0]     data_cnt,
  output logic [CNT_W-1:0]     cfg_cnt,
  output logic [CNT_W-1:0]     bad_cnt,
  output logic                 overflow,
  input  logic                 clear_stats
);

  rx_state_t            state;
  logic [WIDTH-2:0]     cap_word;
  logic                 cap_parity;
  logic                 cap_valid;
  logic [DECLARE_W-1:0] cap_declare;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_head;

  logic                 inc_data;
  logic                 inc_cfg;
  logic                 inc_bad;
  logic                 ovf_set;

  // Unload handshake FSM; strobe covers UNLOAD and CAPTURE, word latched leaving CAPTURE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      uld_rx_data <= 1'b0;
      cap_word    <= '0;
      cap_parity  <= 1'b0;
      cap_valid   <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_empty) begin
            state       <= ST_UNLOAD;
            uld_rx_data <= 1'b1;
          end
        end
        ST_UNLOAD: begin
          state       <= ST_CAPTURE;
          uld_rx_data <= 1'b1;
        end
        ST_CAPTURE: begin
          state       <= ST_DRAIN;
          uld_rx_data <= 1'b0;
          cap_word    <= rx_data;
          cap_parity  <= parity_error;
          cap_valid   <= 1'b1;
        end
        ST_DRAIN: begin
          if (rx_empty) state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          uld_rx_data <= 1'b0;
        end
      endcase
    end
  end

  assign cap_declare = cap_word[DECLARE_LSB +: DECLARE_W];

  // Classification of the word captured on the previous edge
  assign fifo_push = cap_valid && is_pkt_declare(cap_declare);
  assign fifo_pop  = pkt.pkt_valid && pkt.pkt_ready;
  assign inc_data  = cap_valid && (cap_declare == DATA);
  assign inc_cfg   = cap_valid && ((cap_declare == CFG_WRITE) || (cap_declare == CFG_READ));
  assign inc_bad   = cap_valid && (!is_pkt_declare(cap_declare) || cap_parity);
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

  rx_pkt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cap_parity, cap_word}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_cnt <= '0;
      cfg_cnt  <= '0;
      bad_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clear_stats) begin
      data_cnt <= '0;
      cfg_cnt  <= '0;
      bad_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (inc_data) data_cnt <= sat_inc(data_cnt);
      if (inc_cfg)  cfg_cnt  <= sat_inc(cfg_cnt);
      if (inc_bad)  bad_cnt  <= sat_inc(bad_cnt);
      if (ovf_set)  overflow <= 1'b1;
    end
  end

  // FIFO head presentation and field decode
  assign pkt.pkt_valid        = !fifo_empty;
  assign pkt.pkt_word         = fifo_head[WIDTH-2:0];
  assign pkt.pkt_parity_err   = fifo_head[WIDTH-1];
  assign pkt.pkt_type         = pkt.pkt_word[DECLARE_LSB     +: DECLARE_W];
  assign pkt.pkt_chip_id      = pkt.pkt_word[CHIP_ID_LSB     +: CHIP_ID_W];
  assign pkt.pkt_channel_id   = pkt.pkt_word[CHANNEL_ID_LSB  +: CHANNEL_ID_W];
  assign pkt.pkt_timestamp    = pkt.pkt_word[TIMESTAMP_LSB   +: TIMESTAMP_W];
  assign pkt.pkt_data_word    = pkt.pkt_word[DATA_WORD_LSB   +: DATA_WORD_W];
  assign pkt.pkt_trigger_type = pkt.pkt_word[TRIGGER_LSB     +: TRIGGER_W];
  assign pkt.pkt_regmap_addr  = pkt.pkt_word[REGMAP_ADDR_LSB +: REGMAP_ADDR_W];
  assign pkt.pkt_regmap_data  = pkt.pkt_word[REGMAP_DATA_LSB +: REGMAP_DATA_W];

endmodule

// File: tb/tb_larpix_rx_decoder.sv
// Directed bench for larpix_rx_decoder with a simple uart_rx_fpga stand-in.
module tb_larpix_rx_decoder;

  logic        clk;
  logic        reset;
  logic [62:0] rx_data;
  logic        rx_empty;
  logic        parity_error;
  logic        uld_rx_data;
  logic [15:0] data_cnt;
  logic [15:0] cfg_cnt;
  logic [15:0] bad_cnt;
  logic        overflow;
  logic        clear_stats;
  logic        pkt_ready;

  int checks   = 0;
  int failures = 0;

  larpix_rx_decoder_if #(.WIDTH(64)) pkt_if ();
  assign pkt_if.pkt_ready = pkt_ready;

  larpix_rx_decoder #(.WIDTH(64), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .parity_error (parity_error),
    .uld_rx_data  (uld_rx_data),
    .pkt          (pkt_if),
    .data_cnt     (data_cnt),
    .cfg_cnt      (cfg_cnt),
    .bad_cnt      (bad_cnt),
    .overflow     (overflow),
    .clear_stats  (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data packet built from hand-placed bit positions
  function automatic logic [62:0] mk_data(input logic [7:0] chip, input logic [5:0] ch,
                                          input logic [27:0] ts, input logic [9:0] dw);
    logic [62:0] w;
    w = '0;
    w[1:0]   = 2'b01;
    w[9:2]   = chip;
    w[15:10] = ch;
    w[43:16] = ts;
    w[55:46] = dw;
    w[57:56] = 2'b10;
    return w;
  endfunction

  function automatic logic [62:0] mk_cfg(input logic [1:0] dec, input logic [7:0] chip,
                                         input logic [7:0] addr, input logic [7:0] data);
    logic [62:0] w;
    w = '0;
    w[1:0]   = dec;
    w[9:2]   = chip;
    w[17:10] = addr;
    w[25:18] = data;
    return w;
  endfunction

  // Offers one word, counts strobe cycles, optionally pulses clear/ready in the push cycle
  task automatic send_word(input logic [62:0] w, input logic par, input logic clr,
                           input logic rdy, input int hold, output int uld_n);
    logic old_rdy;
    bit   fell;
    old_rdy = pkt_ready;
    uld_n   = 0;
    fell    = 0;
    @(negedge clk);
    rx_data = w; parity_error = par; rx_empty = 1'b0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk);
      if (uld_rx_data) uld_n++;
      else if (uld_n > 0) fell = 1;
    end
    checks++;
    if (!fell) begin
      failures++;
      $display("FAIL send_strobe_timeout got_cycles=%0d exp=strobe_end", uld_n);
    end
    clear_stats = clr;
    pkt_ready   = old_rdy | rdy;
    @(negedge clk);
    clear_stats = 1'b0;
    pkt_ready   = old_rdy;
    if (uld_rx_data) uld_n++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (uld_rx_data) uld_n++;
    end
    rx_empty = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_stats = 1'b1;
    @(negedge clk); clear_stats = 1'b0;
  endtask

  task automatic pop_one();
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (uld_rx_data !== 1'b0) begin failures++; $display("FAIL reset_uld got=%b exp=0", uld_rx_data); end
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_pkt_valid got=%b exp=0", pkt_if.pkt_valid); end
    checks++; if (pkt_if.pkt_word !== 63'd0) begin failures++; $display("FAIL reset_pkt_word got=%h exp=0", pkt_if.pkt_word); end
    checks++; if ({data_cnt, cfg_cnt, bad_cnt} !== 48'd0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {data_cnt, cfg_cnt, bad_cnt}); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_data();
    int n;
    send_word(mk_data(8'd16, 6'd5, 28'd1234, 10'd300), 1'b0, 1'b0, 1'b0, 3, n);
    checks++; if (n !== 2) begin failures++; $display("FAIL single_uld_cycles got=%0d exp=2", n); end
    checks++; if (pkt_if.pkt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", pkt_if.pkt_valid); end
    checks++; if (pkt_if.pkt_type !== 2'd1) begin failures++; $display("FAIL single_type got=%0d exp=1", pkt_if.pkt_type); end
    checks++; if (pkt_if.pkt_chip_id !== 8'd16) begin failures++; $display("FAIL single_chip got=%0d exp=16", pkt_if.pkt_chip_id); end
    checks++; if (pkt_if.pkt_channel_id !== 6'd5) begin failures++; $display("FAIL single_channel got=%0d exp=5", pkt_if.pkt_channel_id); end
    checks++; if (pkt_if.pkt_timestamp !== 28'd1234) begin failures++; $display("FAIL single_ts got=%0d exp=1234", pkt_if.pkt_timestamp); end
    checks++; if (pkt_if.pkt_data_word !== 10'd300) begin failures++; $display("FAIL single_dw got=%0d exp=300", pkt_if.pkt_data_word); end
    checks++; if (pkt_if.pkt_trigger_type !== 2'd2) begin failures++; $display("FAIL single_trig got=%0d exp=2", pkt_if.pkt_trigger_type); end
    checks++; if (pkt_if.pkt_parity_err !== 1'b0) begin failures++; $display("FAIL single_parity got=%b exp=0", pkt_if.pkt_parity_err); end
    checks++; if (data_cnt !== 16'd1) begin failures++; $display("FAIL single_data_cnt got=%0d exp=1", data_cnt); end
    pop_one();
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL single_after_pop got=%b exp=0", pkt_if.pkt_valid); end
  endtask

  task automatic test_bad_declare();
    int n;
    logic [62:0] w;
    w = mk_data(8'd7, 6'd1, 28'd9, 10'd55);
    w[1:0] = 2'b00;
    send_word(w, 1'b0, 1'b0, 1'b0, 0, n);
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL bad_valid got=%b exp=0", pkt_if.pkt_valid); end
    checks++; if (bad_cnt !== 16'd1) begin failures++; $display("FAIL bad_bad_cnt got=%0d exp=1", bad_cnt); end
    checks++; if (data_cnt !== 16'd1) begin failures++; $display("FAIL bad_data_cnt got=%0d exp=1", data_cnt); end
  endtask

  task automatic test_parity_error();
    int n;
    pulse_clear();
    checks++; if ({data_cnt, bad_cnt} !== 32'd0) begin failures++; $display("FAIL clear_counters got=%h exp=0", {data_cnt, bad_cnt}); end
    send_word(mk_cfg(2'b10, 8'd3, 8'h2A, 8'h5C), 1'b1, 1'b0, 1'b0, 0, n);
    checks++; if (pkt_if.pkt_valid !== 1'b1) begin failures++; $display("FAIL par_valid got=%b exp=1", pkt_if.pkt_valid); end
    checks++; if (pkt_if.pkt_parity_err !== 1'b1) begin failures++; $display("FAIL par_flag got=%b exp=1", pkt_if.pkt_parity_err); end
    checks++; if (pkt_if.pkt_type !== 2'd2) begin failures++; $display("FAIL par_type got=%0d exp=2", pkt_if.pkt_type); end
    checks++; if (pkt_if.pkt_regmap_addr !== 8'd42) begin failures++; $display("FAIL par_addr got=%0d exp=42", pkt_if.pkt_regmap_addr); end
    checks++; if (pkt_if.pkt_regmap_data !== 8'd92) begin failures++; $display("FAIL par_data got=%0d exp=92", pkt_if.pkt_regmap_data); end
    checks++; if (cfg_cnt !== 16'd1) begin failures++; $display("FAIL par_cfg_cnt got=%0d exp=1", cfg_cnt); end
    checks++; if (bad_cnt !== 16'd1) begin failures++; $display("FAIL par_bad_cnt got=%0d exp=1", bad_cnt); end
    pop_one();
  endtask

  task automatic test_clear_priority();
    int n;
    send_word(mk_data(8'd9, 6'd2, 28'd77, 10'd640), 1'b1, 1'b1, 1'b0, 0, n);
    checks++; if ({data_cnt, cfg_cnt, bad_cnt} !== 48'd0) begin failures++; $display("FAIL clrpri_counters got=%h exp=0", {data_cnt, cfg_cnt, bad_cnt}); end
    checks++; if (pkt_if.pkt_valid !== 1'b1 || pkt_if.pkt_data_word !== 10'd640) begin failures++; $display("FAIL clrpri_fifo got=%b/%0d exp=1/640", pkt_if.pkt_valid, pkt_if.pkt_data_word); end
    pop_one();
    send_word(mk_cfg(2'b11, 8'd1, 8'h01, 8'hF0), 1'b0, 1'b0, 1'b0, 0, n);
    checks++; if (pkt_if.pkt_type !== 2'd3 || pkt_if.pkt_regmap_data !== 8'hF0) begin failures++; $display("FAIL cfgrd_head got=%0d/%h exp=3/f0", pkt_if.pkt_type, pkt_if.pkt_regmap_data); end
    checks++; if (cfg_cnt !== 16'd1 || bad_cnt !== 16'd0) begin failures++; $display("FAIL cfgrd_counts got=%0d/%0d exp=1/0", cfg_cnt, bad_cnt); end
    pop_one();
  endtask

  task automatic test_overflow();
    int n;
    pulse_clear();
    pkt_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_word(mk_data(8'd1, 6'd0, 28'd0, 10'(i)), 1'b0, 1'b0, 1'b0, 0, n);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%b exp=0", overflow); end
    send_word(mk_data(8'd1, 6'd0, 28'd0, 10'd9), 1'b0, 1'b0, 1'b0, 0, n);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    pkt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (pkt_if.pkt_valid !== 1'b1 || pkt_if.pkt_data_word !== 10'(k)) begin
        failures++; $display("FAIL ovf_pop_%0d got=%b/%0d exp=1/%0d", k, pkt_if.pkt_valid, pkt_if.pkt_data_word, k);
      end
      @(negedge clk);
    end
    pkt_ready = 1'b0;
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", pkt_if.pkt_valid); end
  endtask

  task automatic test_full_pop();
    int n;
    pulse_clear();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%b exp=0", overflow); end
    for (int i = 11; i <= 18; i++) send_word(mk_data(8'd2, 6'd0, 28'd0, 10'(i)), 1'b0, 1'b0, 1'b0, 0, n);
    send_word(mk_data(8'd2, 6'd0, 28'd0, 10'd19), 1'b0, 1'b0, 1'b1, 0, n);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
    pkt_ready = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      checks++;
      if (pkt_if.pkt_valid !== 1'b1 || pkt_if.pkt_data_word !== 10'(k)) begin
        failures++; $display("FAIL fullpop_pop_%0d got=%b/%0d exp=1/%0d", k, pkt_if.pkt_valid, pkt_if.pkt_data_word, k);
      end
      @(negedge clk);
    end
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL fullpop_drained got=%b exp=0", pkt_if.pkt_valid); end
    // Ready held on an empty FIFO must not disturb the pointers
    repeat (3) @(negedge clk);
    pkt_ready = 1'b0;
    send_word(mk_data(8'd4, 6'd4, 28'd4, 10'd77), 1'b0, 1'b0, 1'b0, 0, n);
    checks++; if (pkt_if.pkt_valid !== 1'b1 || pkt_if.pkt_data_word !== 10'd77) begin failures++; $display("FAIL popempty_head got=%b/%0d exp=1/77", pkt_if.pkt_valid, pkt_if.pkt_data_word); end
    pop_one();
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL popempty_single got=%b exp=0", pkt_if.pkt_valid); end
  endtask

  task automatic test_reset_mid_capture();
    int n;
    @(negedge clk);
    rx_data = mk_data(8'd5, 6'd5, 28'd5, 10'd111); parity_error = 1'b0; rx_empty = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (uld_rx_data !== 1'b1) begin failures++; $display("FAIL midcap_strobe got=%b exp=1", uld_rx_data); end
    #1 reset = 1'b1;
    #1;
    checks++; if (uld_rx_data !== 1'b0) begin failures++; $display("FAIL midcap_uld got=%b exp=0", uld_rx_data); end
    rx_empty = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pkt_if.pkt_valid !== 1'b0) begin failures++; $display("FAIL midcap_empty got=%b exp=0", pkt_if.pkt_valid); end
    checks++; if (data_cnt !== 16'd0) begin failures++; $display("FAIL midcap_cnt got=%0d exp=0", data_cnt); end
    send_word(mk_data(8'd3, 6'd9, 28'd42, 10'd500), 1'b0, 1'b0, 1'b0, 0, n);
    checks++; if (n !== 2) begin failures++; $display("FAIL midcap_next_uld got=%0d exp=2", n); end
    checks++; if (pkt_if.pkt_valid !== 1'b1 || pkt_if.pkt_data_word !== 10'd500 || pkt_if.pkt_chip_id !== 8'd3) begin
      failures++; $display("FAIL midcap_next_pkt got=%b/%0d/%0d exp=1/500/3", pkt_if.pkt_valid, pkt_if.pkt_data_word, pkt_if.pkt_chip_id);
    end
    checks++; if (data_cnt !== 16'd1) begin failures++; $display("FAIL midcap_next_cnt got=%0d exp=1", data_cnt); end
    pop_one();
  endtask

  initial begin
    reset        = 1'b1;
    rx_data      = '0;
    rx_empty     = 1'b1;
    parity_error = 1'b0;
    clear_stats  = 1'b0;
    pkt_ready    = 1'b0;
    test_reset();
    test_single_data();
    test_bad_declare();
    test_parity_error();
    test_clear_priority();
    test_overflow();
    test_full_pop();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/larpix_rx_decoder.md
LARPIX_RX_DECODER -- requirements
Module: larpix_rx_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: UART frame width; the received word is WIDTH-1 bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output packet FIFO depth, a power of 2, at least 2.
REQ-003 SHALL have ports: clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: rx_data  input  WIDTH-1  word from uart_rx_fpga.
REQ-006 SHALL have ports: rx_empty  input  1  low means a word is waiting in uart_rx_fpga; parity_error  input  1  parity flag for that word.
REQ-007 SHALL have ports: uld_rx_data  output  1  unload strobe to uart_rx_fpga.
REQ-008 SHALL have ports: pkt_valid  output  1; pkt_ready  input  1; pkt_word  output  WIDTH-1; pkt_parity_err  output  1 (FIFO head).
REQ-009 SHALL have ports: pkt_type  output  2; pkt_chip_id  output  8; pkt_channel_id  output  6; pkt_timestamp  output  28; pkt_data_word  output  10; pkt_trigger_type  output  2; pkt_regmap_addr  output  8; pkt_regmap_data  output  8. All are decoded combinationally from pkt_word.
REQ-010 SHALL have ports: data_cnt, cfg_cnt, bad_cnt  output  16 each; overflow  output  1; clear_stats  input  1.

Function
REQ-011 SHALL implement FSM IDLE->UNLOAD->CAPTURE->DRAIN->IDLE.
REQ-012 SHALL leave IDLE for UNLOAD on the edge where rx_empty==0.
REQ-013 SHALL drive uld_rx_data=1 in UNLOAD and in CAPTURE, so the strobe is exactly 2 cycles, and 0 otherwise.
REQ-014 SHALL register rx_data and parity_error on the clock edge that leaves CAPTURE.
REQ-015 SHALL hold DRAIN until rx_empty==1 and then go to IDLE, so each word is unloaded only once.
REQ-016 SHALL decode fields from the captured word: declare [1:0], chip_id [9:2], channel_id [15:10], timestamp [43:16], data_word [55:46], trigger [57:56], regmap_addr [17:10], regmap_data [25:18].
REQ-017 SHALL discard a captured word with declare==2'b00, increment bad_cnt, and not push it to the FIFO.
REQ-018 SHALL push a captured word with declare 01, 10 or 11 to the FIFO, one cycle after capture, together with its parity flag.
REQ-019 SHALL increment data_cnt for declare 01 and cfg_cnt for declare 10 or 11.
REQ-020 SHALL also increment bad_cnt for a pushed word whose parity_error==1.
REQ-021 SHALL saturate all counters at 16'hFFFF with no wrap.
REQ-022 SHALL present the FIFO head first-word-fall-through: pkt_valid=~empty, and a pop occurs on a cycle with pkt_valid && pkt_ready.
REQ-023 SHALL drop a push to a full FIFO with no pop that cycle, keep FIFO contents unchanged, and set overflow sticky.
REQ-024 SHALL accept a push to a full FIFO when a pop occurs the same cycle, leaving the count unchanged.
REQ-025 SHALL perform a pop only when the FIFO is empty being false, and SHALL have no effect from pkt_ready while empty.
REQ-026 SHALL, when clear_stats==1, zero all three counters and overflow on the next edge; clear SHALL take priority over a same-cycle increment.
REQ-027 SHALL leave FIFO contents and FSM state unaffected by clear_stats.

Reset
REQ-028 SHALL, while reset is high, force FSM=IDLE, uld_rx_data=0, FIFO empty (pkt_valid=0), pkt_word=0, all counters 0 and overflow=0, asynchronously.
REQ-029 SHALL discard a word in flight when reset asserts in UNLOAD or CAPTURE; after release the FSM restarts from IDLE per REQ-012.

Structure
REQ-030 SHALL place packet-declare constants (DATA=2'b01, CFG_WRITE=2'b10, CFG_READ=2'b11) and field LSB/width constants in the shared larpix constants package.
REQ-031 SHALL implement the FIFO as a sub-module rx_pkt_fifo with parameters WIDTH and DEPTH and ports for push, pop, full, empty and head; the FIFO entry is the word plus its parity bit.

Verification
REQ-032 SHALL be verified by test 1, single data packet: rx_empty falls with rx_data declare=01, chip 16, channel 5, data_word 300 -> uld_rx_data high exactly 2 cycles; pkt_valid rises with chip_id 16, channel 5, data_word 300; data_cnt=1.
REQ-033 SHALL be verified by test 2, bad declare: a word with [1:0]=00 -> FIFO stays empty and bad_cnt=1.
REQ-034 SHALL be verified by test 3, parity error: a config write (declare 10) with parity_error=1, addr 8'h2A, data 8'h5C -> pkt_parity_err=1, regmap_addr 42, regmap_data 92; cfg_cnt=1 and bad_cnt=1.
REQ-035 SHALL be verified by test 4, overflow: pkt_ready=0 and 9 data packets -> 8 entries held, overflow=1, and words 1-8 pop in order once pkt_ready=1.
REQ-036 SHALL be verified by test 5, full with simultaneous pop: FIFO full and pkt_ready=1 while packet 9 arrives -> packet 9 accepted and overflow stays 0.
REQ-037 SHALL be verified by test 6, reset mid-capture: reset asserted during CAPTURE -> uld_rx_data=0 immediately, FIFO empty, and the next rx_empty fall is processed normally.
